// File: rtl/mac_acc_seq.sv
// rtl/mac_acc_seq.sv - vector accumulation sequencer in front of a registered 4-lane MAC
module mac_acc_seq #(
    parameter int bw      = 4,
    parameter int psum_bw = 16,
    parameter int cnt_bw  = 8
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic                 in_last,
    input  logic [4*bw-1:0]      in_a,
    input  logic [4*bw-1:0]      in_b,
    output logic [4*bw-1:0]      mac_a,
    output logic [4*bw-1:0]      mac_b,
    output logic [psum_bw-1:0]   mac_c,
    input  logic [psum_bw-1:0]   mac_out,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [psum_bw-1:0]   out_psum,
    output logic [cnt_bw-1:0]    out_count
);

    typedef enum logic [1:0] {
        S_ACCEPT = 2'd0,
        S_WAIT   = 2'd1,
        S_HOLD   = 2'd2
    } state_t;

    localparam logic [cnt_bw-1:0] CNT_MAX = '1;
    localparam logic [cnt_bw-1:0] CNT_ONE = cnt_bw'(1);

    state_t               state_q, state_d;
    logic [psum_bw-1:0]   psum_q, psum_d;
    logic [cnt_bw-1:0]    count_q, count_d;
    logic                 first_q, first_d;
    logic                 last_q, last_d;
    // first_q is cleared on acceptance, so the WAIT cycle needs its own copy
    // to know whether the vector in flight opened a new group.
    logic                 vec_first_q, vec_first_d;

    // State register; reset discards any group in flight.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q     <= S_ACCEPT;
            psum_q      <= '0;
            count_q     <= '0;
            first_q     <= 1'b1;
            last_q      <= 1'b0;
            vec_first_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            psum_q      <= psum_d;
            count_q     <= count_d;
            first_q     <= first_d;
            last_q      <= last_d;
            vec_first_q <= vec_first_d;
        end
    end

    // Next-state: accept a vector, capture the MAC result a cycle later, then hold any group result.
    always_comb begin
        state_d     = state_q;
        psum_d      = psum_q;
        count_d     = count_q;
        first_d     = first_q;
        last_d      = last_q;
        vec_first_d = vec_first_q;
        case (state_q)
            S_ACCEPT: begin
                if (in_valid) begin
                    last_d      = in_last;
                    vec_first_d = first_q;
                    first_d     = 1'b0;
                    state_d     = S_WAIT;
                end
            end
            S_WAIT: begin
                psum_d = mac_out;
                if (vec_first_q) begin
                    count_d = CNT_ONE;
                end else if (count_q != CNT_MAX) begin
                    count_d = count_q + CNT_ONE;
                end
                state_d = last_q ? S_HOLD : S_ACCEPT;
            end
            S_HOLD: begin
                if (out_ready) begin
                    first_d = 1'b1;
                    state_d = S_ACCEPT;
                end
            end
            default: state_d = S_ACCEPT;
        endcase
    end

    assign mac_a     = in_a;
    assign mac_b     = in_b;
    assign mac_c     = first_q ? '0 : psum_q;
    assign in_ready  = (state_q == S_ACCEPT) && reset;
    assign out_valid = (state_q == S_HOLD);
    assign out_psum  = psum_q;
    assign out_count = count_q;

endmodule

// File: tb/tb_mac_acc_seq.sv
// tb/tb_mac_acc_seq.sv - self-checking bench for mac_acc_seq with a registered MAC model
module tb_mac_acc_seq;

    localparam int BW      = 4;
    localparam int PSUM_BW = 16;
    localparam int CNT_BW  = 2;
    localparam int CNT_MAX = (1 << CNT_BW) - 1;

    logic                 clk = 1'b0;
    logic                 reset;
    logic                 in_valid;
    logic                 in_ready;
    logic                 in_last;
    logic [4*BW-1:0]      in_a;
    logic [4*BW-1:0]      in_b;
    logic [4*BW-1:0]      mac_a;
    logic [4*BW-1:0]      mac_b;
    logic [PSUM_BW-1:0]   mac_c;
    logic [PSUM_BW-1:0]   mac_out;
    logic                 out_valid;
    logic                 out_ready;
    logic [PSUM_BW-1:0]   out_psum;
    logic [CNT_BW-1:0]    out_count;

    int n_checks = 0;
    int n_fail   = 0;

    int ref_psum  = 0;
    int ref_cnt   = 0;
    bit ref_first = 1'b1;

    always #5 clk = ~clk;

    mac_acc_seq #(.bw(BW), .psum_bw(PSUM_BW), .cnt_bw(CNT_BW)) dut (
        .clk       (clk),
        .reset     (reset),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_last   (in_last),
        .in_a      (in_a),
        .in_b      (in_b),
        .mac_a     (mac_a),
        .mac_b     (mac_b),
        .mac_c     (mac_c),
        .mac_out   (mac_out),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_psum  (out_psum),
        .out_count (out_count)
    );

    function automatic int dot(input logic [4*BW-1:0] a, input logic [4*BW-1:0] b);
        int s = 0;
        for (int i = 0; i < 4; i++) begin
            s += int'(a[BW*i +: BW]) * int'(b[BW*i +: BW]);
        end
        return s;
    endfunction

    // Registered MAC wrapper: result appears one cycle after it samples its inputs.
    always @(posedge clk) begin
        mac_out <= PSUM_BW'(dot(mac_a, mac_b) + int'(mac_c));
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Offer one vector at a negedge in ACCEPT and walk it through WAIT.
    task automatic send_vec(input logic [4*BW-1:0] a, input logic [4*BW-1:0] b,
                            input bit last, input bit noise_in_wait);
        int guard = 0;
        while (!in_ready && guard < 20) begin
            @(negedge clk);
            guard++;
        end
        check("in_ready_accept", 32'(in_ready), 32'(1));
        check("out_valid_accept", 32'(out_valid), 32'(0));
        check("mac_c_accept", 32'(mac_c), ref_first ? 32'(0) : 32'(ref_psum));
        in_valid = 1'b1;
        in_a     = a;
        in_b     = b;
        in_last  = last;
        #1;
        check("mac_a_pass", 32'(mac_a), 32'(a));
        check("mac_b_pass", 32'(mac_b), 32'(b));
        @(posedge clk);
        ref_psum  = ((ref_first ? 0 : ref_psum) + dot(a, b)) % (1 << PSUM_BW);
        ref_cnt   = ref_first ? 1 : ((ref_cnt < CNT_MAX) ? ref_cnt + 1 : CNT_MAX);
        ref_first = 1'b0;
        @(negedge clk);
        if (noise_in_wait) begin
            in_a      = 16'($urandom);
            in_b      = 16'($urandom);
            in_last   = 1'($urandom);
            out_ready = 1'($urandom);
        end else begin
            in_valid = 1'b0;
        end
        check("in_ready_wait", 32'(in_ready), 32'(0));
        check("out_valid_wait", 32'(out_valid), 32'(0));
        @(posedge clk);
        @(negedge clk);
        in_valid  = 1'b0;
        out_ready = 1'b0;
        if (last) begin
            check("out_valid_hold", 32'(out_valid), 32'(1));
            check("out_psum", 32'(out_psum), 32'(ref_psum));
            check("out_count", 32'(out_count), 32'(ref_cnt));
            check("in_ready_hold", 32'(in_ready), 32'(0));
        end else begin
            check("out_valid_mid", 32'(out_valid), 32'(0));
            check("in_ready_mid", 32'(in_ready), 32'(1));
        end
    endtask

    // In HOLD: stall for some cycles, then release the result.
    task automatic drain(input int stall);
        for (int k = 0; k < stall; k++) begin
            @(posedge clk);
            @(negedge clk);
            check("stall_out_valid", 32'(out_valid), 32'(1));
            check("stall_out_psum", 32'(out_psum), 32'(ref_psum));
            check("stall_out_count", 32'(out_count), 32'(ref_cnt));
            check("stall_in_ready", 32'(in_ready), 32'(0));
        end
        out_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        out_ready = 1'b0;
        ref_first = 1'b1;
        check("release_out_valid", 32'(out_valid), 32'(0));
        check("release_in_ready", 32'(in_ready), 32'(1));
    endtask

    task automatic check_reset_values(input string tag);
        check({tag, "_in_ready"}, 32'(in_ready), 32'(0));
        check({tag, "_out_valid"}, 32'(out_valid), 32'(0));
        check({tag, "_out_psum"}, 32'(out_psum), 32'(0));
        check({tag, "_out_count"}, 32'(out_count), 32'(0));
        check({tag, "_mac_c"}, 32'(mac_c), 32'(0));
    endtask

    task automatic release_reset();
        @(negedge clk);
        reset = 1'b1;
        #1;
        check("in_ready_after_reset", 32'(in_ready), 32'(1));
        ref_psum  = 0;
        ref_cnt   = 0;
        ref_first = 1'b1;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            check("no_pulse_after_reset", 32'(out_valid), 32'(0));
        end
    endtask

    initial begin
        reset     = 1'b0;
        in_valid  = 1'b0;
        in_last   = 1'b0;
        in_a      = '0;
        in_b      = '0;
        out_ready = 1'b0;
        @(negedge clk);
        @(negedge clk);
        check_reset_values("reset");
        release_reset();

        // Single-vector group
        send_vec(16'h4321, 16'h1111, 1'b1, 1'b0);
        check("single_psum", 32'(out_psum), 32'(10));
        check("single_count", 32'(out_count), 32'(1));
        drain(0);

        // Two-vector group with backpressure
        send_vec(16'h4321, 16'h1111, 1'b0, 1'b0);
        send_vec(16'h4321, 16'h1111, 1'b1, 1'b0);
        check("two_psum", 32'(out_psum), 32'(20));
        check("two_count", 32'(out_count), 32'(2));
        drain(5);

        // Group boundary restarts from zero
        send_vec(16'h0002, 16'h0003, 1'b1, 1'b0);
        check("boundary_psum", 32'(out_psum), 32'(6));
        check("boundary_count", 32'(out_count), 32'(1));
        drain(1);

        // Reset while in WAIT
        in_valid = 1'b1;
        in_a     = 16'h9999;
        in_b     = 16'h7777;
        in_last  = 1'b1;
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        reset    = 1'b0;
        #1;
        check_reset_values("reset_wait");
        release_reset();
        send_vec(16'h1111, 16'h1111, 1'b1, 1'b0);
        check("after_reset_psum", 32'(out_psum), 32'(4));
        check("after_reset_count", 32'(out_count), 32'(1));

        // Reset while in HOLD
        reset = 1'b0;
        #1;
        check_reset_values("reset_hold");
        release_reset();

        // Counter saturation
        for (int v = 0; v < 5; v++) begin
            send_vec(16'h2222, 16'h3333, v == 4, 1'b0);
        end
        check("sat_count", 32'(out_count), 32'(CNT_MAX));
        check("sat_psum", 32'(out_psum), 32'(120));
        drain(2);

        // Randomized groups, with in_valid/out_ready noise while not accepting
        for (int g = 0; g < 20; g++) begin
            int len = int'($urandom_range(1, 6));
            for (int v = 0; v < len; v++) begin
                send_vec(16'($urandom), 16'($urandom), v == len - 1, 1'($urandom));
            end
            drain(int'($urandom_range(0, 3)));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/mac_acc_seq.md
MAC_ACC_SEQ -- requirements
Module: mac_acc_seq

Interface
REQ-001 Parameter bw, default 4: per-lane activation/weight width.
REQ-002 Parameter psum_bw, default 16: partial-sum width.
REQ-003 Parameter cnt_bw, default 8: width of the accumulated-vector counter.
REQ-004 clk  input  1  single clock; all state updates on its rising edge.
REQ-005 reset  input  1  asynchronous, active-low reset.
REQ-006 in_valid  input  1  upstream vector valid.
REQ-007 in_ready  output  1  block can accept a vector this cycle.
REQ-008 in_last  input  1  accepted vector is the last of its accumulation group.
REQ-009 in_a  input  4*bw  activations; lane i at bits [bw*i +: bw].
REQ-010 in_b  input  4*bw  weights; same lane packing as in_a.
REQ-011 mac_a  output  4*bw  to the 4-lane MAC wrapper a0..a3; lane i maps to a_i.
REQ-012 mac_b  output  4*bw  to the wrapper b0..b3.
REQ-013 mac_c  output  psum_bw  to the wrapper c input.
REQ-014 mac_out  input  psum_bw  from the wrapper out; valid one cycle after the wrapper samples its inputs.
REQ-015 out_valid  output  1  completed group result valid.
REQ-016 out_ready  input  1  downstream accepts the result.
REQ-017 out_psum  output  psum_bw  accumulated group result.
REQ-018 out_count  output  cnt_bw  number of vectors in the reported group.

Function
REQ-019 The block SHALL implement three states: ACCEPT, WAIT, HOLD.
REQ-020 mac_a and mac_b SHALL equal in_a and in_b combinationally in every state.
REQ-021 mac_c SHALL be 0 when the first flag is set, otherwise psum_q, in every state.
REQ-022 in_ready SHALL be 1 only in ACCEPT with reset deasserted.
REQ-023 ACCEPT, in_valid=1: latch in_last into last_q, clear first, go to WAIT.
REQ-024 ACCEPT, in_valid=0: hold all state.
REQ-025 WAIT: psum_q <= mac_out; count <= (first-of-group ? 1 : count+1); go to HOLD if last_q=1, else to ACCEPT.
REQ-026 The counter SHALL saturate at 2^cnt_bw-1 and SHALL NOT wrap.
REQ-027 HOLD: out_valid=1, out_psum=psum_q, out_count=count; all three held stable until out_ready=1.
REQ-028 HOLD with out_ready=1: set first, go to ACCEPT; out_valid deasserts on the next cycle.
REQ-029 out_valid SHALL be 0 in ACCEPT and WAIT; out_ready SHALL be ignored outside HOLD.
REQ-030 Throughput SHALL be one vector per 2 cycles; a group result is visible 1 cycle after the WAIT of its last vector.
REQ-031 Latency SHALL be 2 cycles from acceptance of the last vector to out_valid=1 (single-vector group included).
REQ-032 Arithmetic (product sum, wrap of psum_bw overflow) SHALL be owned by the MAC; this block SHALL pass mac_out unmodified.
REQ-033 in_valid while in_ready=0 SHALL be ignored; upstream holds data (standard valid/ready).

Reset
REQ-034 reset=0 SHALL immediately force: state ACCEPT, psum_q=0, count=0, first=1, last_q=0, out_valid=0, in_ready=0.
REQ-035 Reset asserted in WAIT or HOLD SHALL discard the group; no out_valid pulse after release.
REQ-036 After reset release, in_ready SHALL be 1 on the first cycle.

Verification
REQ-037 Single group: in_a lanes {1,2,3,4}, in_b {1,1,1,1}, in_last=1 -> out_psum=10, out_count=1, out_valid 2 cycles after accept.
REQ-038 Two-vector group: {1,2,3,4}x{1,1,1,1}, then the same with in_last=1 -> second mac_c=10, out_psum=20, out_count=2.
REQ-039 Backpressure: out_ready=0 for 5 cycles in HOLD -> out_valid, out_psum, out_count stable; in_ready=0 throughout; release -> in_ready=1 next cycle.
REQ-040 Group boundary: after a result of 20, new group {2,0,0,0}x{3,0,0,0} last -> mac_c=0 on accept, out_psum=6, out_count=1.
REQ-041 Reset mid-group in WAIT -> outputs at reset values; next group {1,1,1,1}x{1,1,1,1} -> out_psum=4, out_count=1.
REQ-042 Saturation, cnt_bw=2: 5-vector group -> out_count=3.
